// File: rtl/ddr_rd_arbiter.sv
// Two-channel DDR read scheduler feeding the CH0/CH1 display FIFOs from per-channel frame buffers.
// Define DDR_RD_ARB_FIXED_PRIO_EN to give CH0 fixed priority instead of round-robin.
module ddr_rd_arbiter #(
    parameter int                BURST_LEN   = 64,
    parameter int                ADDR_W      = 28,
    parameter int                LVL_W       = 10,
    parameter int                LOW_WATER   = 384,
    parameter int                FRAME_WORDS = 76800,
    parameter logic [ADDR_W-1:0] CH0_BASE    = '0,
    parameter logic [ADDR_W-1:0] CH1_BASE    = ADDR_W'('h200000)
) (
    input  logic              ddr_clk,
    input  logic              ddr_rst,
    input  logic              ddr_init_done,
    input  logic              frame_start,
    input  logic [LVL_W-1:0]  ch0_fifo_level,
    input  logic [LVL_W-1:0]  ch1_fifo_level,
    output logic              rd_cmd_valid,
    input  logic              rd_cmd_ready,
    output logic [ADDR_W-1:0] rd_cmd_addr,
    output logic [8:0]        rd_cmd_len,
    input  logic              rd_data_valid,
    input  logic [63:0]       rd_data,
    output logic              ch0_fifo_wr_en,
    output logic              ch1_fifo_wr_en,
    output logic [63:0]       fifo_wr_data,
    output logic              busy
);

    // state  | meaning
    // IDLE   | waiting for DDR calibration
    // ARB    | frame reload or pick next channel
    // CMD    | read command presented, waiting for ready
    // DATA   | steering returned beats into granted FIFO

    localparam int                REM_RAW   = $clog2(FRAME_WORDS + 1);
    localparam int                REM_W     = (REM_RAW > 10) ? REM_RAW : 10;
    localparam logic [REM_W-1:0]  FRAME_REM = REM_W'(FRAME_WORDS);
    localparam logic [REM_W-1:0]  BURST_REM = REM_W'(BURST_LEN);
    localparam logic [8:0]        BURST_L9  = 9'(BURST_LEN);
    localparam logic [LVL_W-1:0]  LOW_LVL   = LVL_W'(LOW_WATER);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_CMD, S_DATA} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ch_addr [2];
    logic [REM_W-1:0]   ch_rem  [2];
    logic               pending_q;
    logic               rr_ptr_q;
    logic               grant_q;
    logic [ADDR_W-1:0]  cmd_addr_q;
    logic [8:0]         cmd_len_q;
    logic [8:0]         beat_cnt_q;
    logic               ch0_wr_q, ch1_wr_q;
    logic [63:0]        wr_data_q;

    logic               elig0, elig1, reload, pick_ch1, burst_done;
    logic [REM_W-1:0]   grant_rem;
    logic [8:0]         grant_len;

    assign elig0  = (ch0_fifo_level <= LOW_LVL) && (ch_rem[0] != '0);
    assign elig1  = (ch1_fifo_level <= LOW_LVL) && (ch_rem[1] != '0);
    assign reload = frame_start || pending_q;

`ifdef DDR_RD_ARB_FIXED_PRIO_EN
    assign pick_ch1 = elig1 && !elig0;
`else
    // rr_ptr_q = 1 favours CH1, i.e. CH0 was granted last
    assign pick_ch1 = elig1 && (!elig0 || rr_ptr_q);
`endif

    assign grant_rem  = pick_ch1 ? ch_rem[1] : ch_rem[0];
    assign grant_len  = (grant_rem >= BURST_REM) ? BURST_L9 : grant_rem[8:0];
    assign burst_done = rd_data_valid && (beat_cnt_q == cmd_len_q - 9'd1);

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ddr_init_done) state_d = S_ARB;
            S_ARB:   if (!reload && (elig0 || elig1)) state_d = S_CMD;
            S_CMD:   if (rd_cmd_ready) state_d = S_DATA;
            S_DATA:  if (burst_done) state_d = S_ARB;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            ch_addr[0] <= CH0_BASE;
            ch_addr[1] <= CH1_BASE;
            ch_rem[0]  <= FRAME_REM;
            ch_rem[1]  <= FRAME_REM;
            pending_q  <= 1'b0;
            rr_ptr_q   <= 1'b0;
            grant_q    <= 1'b0;
            cmd_addr_q <= '0;
            cmd_len_q  <= '0;
            beat_cnt_q <= '0;
            ch0_wr_q   <= 1'b0;
            ch1_wr_q   <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            ch0_wr_q <= 1'b0;
            ch1_wr_q <= 1'b0;
            case (state_q)
                S_ARB: begin
                    if (reload) begin
                        ch_addr[0] <= CH0_BASE;
                        ch_addr[1] <= CH1_BASE;
                        ch_rem[0]  <= FRAME_REM;
                        ch_rem[1]  <= FRAME_REM;
                        pending_q  <= 1'b0;
                        rr_ptr_q   <= 1'b0;
                    end else if (elig0 || elig1) begin
                        grant_q    <= pick_ch1;
                        rr_ptr_q   <= !pick_ch1;
                        cmd_addr_q <= pick_ch1 ? ch_addr[1] : ch_addr[0];
                        cmd_len_q  <= grant_len;
                        beat_cnt_q <= '0;
                    end
                end
                S_CMD: begin
                    if (frame_start) pending_q <= 1'b1;
                    if (rd_cmd_ready) begin
                        ch_addr[grant_q] <= ch_addr[grant_q] + ADDR_W'(cmd_len_q);
                        ch_rem[grant_q]  <= ch_rem[grant_q] - REM_W'(cmd_len_q);
                    end
                end
                S_DATA: begin
                    if (frame_start) pending_q <= 1'b1;
                    if (rd_data_valid) begin
                        ch0_wr_q   <= !grant_q;
                        ch1_wr_q   <= grant_q;
                        wr_data_q  <= rd_data;
                        beat_cnt_q <= beat_cnt_q + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_cmd_valid   = (state_q == S_CMD);
    assign busy           = (state_q == S_CMD) || (state_q == S_DATA);
    assign rd_cmd_addr    = cmd_addr_q;
    assign rd_cmd_len     = cmd_len_q;
    assign ch0_fifo_wr_en = ch0_wr_q;
    assign ch1_fifo_wr_en = ch1_wr_q;
    assign fifo_wr_data   = wr_data_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed-plus-random bench for ddr_rd_arbiter; a short frame (100 words) exercises the frame tail.
module tb_ddr_rd_arbiter;

    localparam int          BURST     = 64;
    localparam int          LOW_WATER = 384;
    localparam int          FRAME     = 100;
    localparam logic [27:0] BASE0     = 28'h0;
    localparam logic [27:0] BASE1     = 28'h200000;

    logic        ddr_clk = 1'b0;
    logic        ddr_rst;
    logic        ddr_init_done;
    logic        frame_start;
    logic [9:0]  ch0_fifo_level;
    logic [9:0]  ch1_fifo_level;
    logic        rd_cmd_valid;
    logic        rd_cmd_ready;
    logic [27:0] rd_cmd_addr;
    logic [8:0]  rd_cmd_len;
    logic        rd_data_valid;
    logic [63:0] rd_data;
    logic        ch0_fifo_wr_en;
    logic        ch1_fifo_wr_en;
    logic [63:0] fifo_wr_data;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // reference model: per-channel next address / words left, last granted channel, pending restart
    logic [27:0] m_addr [2];
    int          m_rem  [2];
    int          m_last;
    bit          m_pending;

    ddr_rd_arbiter #(
        .BURST_LEN   (BURST),
        .ADDR_W      (28),
        .LVL_W       (10),
        .LOW_WATER   (LOW_WATER),
        .FRAME_WORDS (FRAME),
        .CH0_BASE    (BASE0),
        .CH1_BASE    (BASE1)
    ) dut (
        .ddr_clk        (ddr_clk),
        .ddr_rst        (ddr_rst),
        .ddr_init_done  (ddr_init_done),
        .frame_start    (frame_start),
        .ch0_fifo_level (ch0_fifo_level),
        .ch1_fifo_level (ch1_fifo_level),
        .rd_cmd_valid   (rd_cmd_valid),
        .rd_cmd_ready   (rd_cmd_ready),
        .rd_cmd_addr    (rd_cmd_addr),
        .rd_cmd_len     (rd_cmd_len),
        .rd_data_valid  (rd_data_valid),
        .rd_data        (rd_data),
        .ch0_fifo_wr_en (ch0_fifo_wr_en),
        .ch1_fifo_wr_en (ch1_fifo_wr_en),
        .fifo_wr_data   (fifo_wr_data),
        .busy           (busy)
    );

    always #5 ddr_clk = ~ddr_clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reload();
        m_addr[0] = BASE0;
        m_addr[1] = BASE1;
        m_rem[0]  = FRAME;
        m_rem[1]  = FRAME;
        m_last    = 1;
        m_pending = 0;
    endtask

    function automatic bit would_request(input int ch);
        int lvl;
        lvl = (ch == 0) ? int'(ch0_fifo_level) : int'(ch1_fifo_level);
        return (lvl <= LOW_WATER) && (m_pending || m_rem[ch] != 0);
    endfunction

    task automatic model_arb(output int ch);
        bit e0, e1;
        if (m_pending) model_reload();
        e0 = would_request(0);
        e1 = would_request(1);
        if (e0 && e1)  ch = (m_last == 0) ? 1 : 0;
        else if (e0)   ch = 0;
        else if (e1)   ch = 1;
        else           ch = -1;
        if (ch >= 0) m_last = ch;
    endtask

    task automatic expect_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge ddr_clk);
            check("no_cmd", rd_cmd_valid, 1'b0);
            check("not_busy", busy, 1'b0);
        end
    endtask

    task automatic fs_in_arb();
        frame_start = 1'b1;
        @(negedge ddr_clk);
        frame_start = 1'b0;
        model_reload();
    endtask

    function automatic int rand_lvl();
        case ($urandom_range(0, 4))
            0:       return LOW_WATER - 1;
            1:       return LOW_WATER;
            2:       return LOW_WATER + 1;
            3:       return int'($urandom_range(0, LOW_WATER));
            default: return int'($urandom_range(0, 1023));
        endcase
    endfunction

    // One burst: wait for command, check it against the model, handshake, return beats.
    task automatic do_burst(input int exp_wait, input int rdy_delay, input int gap_pct,
                            input int fs_beat, input int abort_beat);
        int ch, n, beats, pulses, guard, el;
        logic [27:0] ea;
        logic        v, wr_mine, wr_other;
        logic [63:0] d;
        model_arb(ch);
        if (ch < 0) ch = 0;
        ea = m_addr[ch];
        el = (m_rem[ch] > BURST) ? BURST : m_rem[ch];
        n = 0;
        while (rd_cmd_valid !== 1'b1 && n < 20) begin
            @(negedge ddr_clk);
            n++;
        end
        check("cmd_valid", rd_cmd_valid, 1'b1);
        if (exp_wait >= 0) check("req_latency", n, exp_wait);
        check("cmd_addr", rd_cmd_addr, ea);
        check("cmd_len", rd_cmd_len, el);
        check("busy_cmd", busy, 1'b1);
        for (int i = 0; i < rdy_delay; i++) begin
            @(negedge ddr_clk);
            check("hold_valid", rd_cmd_valid, 1'b1);
            check("hold_addr", rd_cmd_addr, ea);
            check("hold_len", rd_cmd_len, el);
        end
        rd_cmd_ready = 1'b1;
        @(negedge ddr_clk);
        rd_cmd_ready = 1'b0;
        check("valid_drop", rd_cmd_valid, 1'b0);
        check("busy_data", busy, 1'b1);
        m_addr[ch] = m_addr[ch] + 28'(el);
        m_rem[ch]  = m_rem[ch] - el;
        beats = 0; pulses = 0; guard = 0;
        while (beats < el && guard < 4 * BURST + 50) begin
            v = ($urandom_range(0, 99) >= gap_pct);
            d = {$urandom, $urandom};
            rd_data_valid = v;
            rd_data       = d;
            frame_start   = v && (beats == fs_beat);
            if (frame_start) m_pending = 1;
            @(negedge ddr_clk);
            rd_data_valid = 1'b0;
            frame_start   = 1'b0;
            guard++;
            wr_mine  = (ch == 1) ? ch1_fifo_wr_en : ch0_fifo_wr_en;
            wr_other = (ch == 1) ? ch0_fifo_wr_en : ch1_fifo_wr_en;
            check((ch == 1) ? "ch1_wr_en" : "ch0_wr_en", wr_mine, v);
            check("other_wr_en", wr_other, 1'b0);
            if (wr_mine === 1'b1) pulses++;
            if (v) begin
                check("wr_data", fifo_wr_data, d);
                beats++;
            end
            if (beats == abort_beat) return;
        end
        check("burst_pulses", pulses, el);
    endtask

    initial begin
        ddr_rst        = 1'b1;
        ddr_init_done  = 1'b0;
        frame_start    = 1'b0;
        ch0_fifo_level = '0;
        ch1_fifo_level = '0;
        rd_cmd_ready   = 1'b0;
        rd_data_valid  = 1'b0;
        rd_data        = '0;
        model_reload();
        repeat (3) @(negedge ddr_clk);
        check("rst_valid", rd_cmd_valid, 1'b0);
        check("rst_addr", rd_cmd_addr, 28'h0);
        check("rst_len", rd_cmd_len, 9'h0);
        check("rst_wr0", ch0_fifo_wr_en, 1'b0);
        check("rst_wr1", ch1_fifo_wr_en, 1'b0);
        check("rst_data", fifo_wr_data, 64'h0);
        check("rst_busy", busy, 1'b0);
        ddr_rst = 1'b0;

        // init gating; stray data beats must be ignored outside DATA
        for (int i = 0; i < 100; i++) begin
            rd_data_valid = 1'($urandom_range(0, 1));
            rd_data       = {$urandom, $urandom};
            @(negedge ddr_clk);
            check("gate_valid", rd_cmd_valid, 1'b0);
            check("gate_wr0", ch0_fifo_wr_en, 1'b0);
            check("gate_wr1", ch1_fifo_wr_en, 1'b0);
        end
        rd_data_valid = 1'b0;
        ddr_init_done = 1'b1;
        do_burst(2, 0, 0, -1, -1);

        // round-robin to frame tail; init falling mid-operation is ignored
        ddr_init_done = 1'b0;
        do_burst(1, 0, 0, -1, -1);
        do_burst(1, 0, 0, -1, -1);
        do_burst(1, 0, 0, -1, -1);
        expect_idle(20);
        ddr_init_done = 1'b1;

        // watermark boundary
        ch0_fifo_level = 10'(LOW_WATER + 1);
        fs_in_arb();
        do_burst(1, 0, 0, -1, -1);
        ch0_fifo_level = 10'(LOW_WATER);
        // frame_start during beat 10 of this burst
        do_burst(1, 0, 0, 10, -1);
        do_burst(2, 0, 0, -1, -1);

        // backpressure
        do_burst(1, 20, 0, -1, -1);

        // randomized phase
        for (int it = 0; it < 40; it++) begin
            int ew;
            ch0_fifo_level = 10'(rand_lvl());
            ch1_fifo_level = 10'(rand_lvl());
            if (!would_request(0) && !would_request(1)) begin
                if (m_pending) begin
                    model_reload();
                    expect_idle(3);
                end else if (m_rem[0] == 0 && m_rem[1] == 0) begin
                    fs_in_arb();
                end else begin
                    expect_idle(3);
                end
            end else begin
                ew = m_pending ? 2 : 1;
                do_burst(ew, int'($urandom_range(0, 3)), int'($urandom_range(0, 50)),
                         ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 10)) : -1, -1);
            end
        end

        // reset asserted mid-burst with data in flight
        ch0_fifo_level = '0;
        ch1_fifo_level = '0;
        if (!m_pending && m_rem[0] == 0 && m_rem[1] == 0) fs_in_arb();
        do_burst(m_pending ? 2 : 1, 0, 0, -1, 5);
        ddr_rst       = 1'b1;
        rd_data_valid = 1'b1;
        rd_data       = 64'hDEAD_BEEF_0123_4567;
        @(negedge ddr_clk);
        check("mrst_valid", rd_cmd_valid, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_wr0", ch0_fifo_wr_en, 1'b0);
        check("mrst_wr1", ch1_fifo_wr_en, 1'b0);
        check("mrst_data", fifo_wr_data, 64'h0);
        check("mrst_addr", rd_cmd_addr, 28'h0);
        check("mrst_len", rd_cmd_len, 9'h0);
        ddr_rst       = 1'b0;
        rd_data_valid = 1'b0;
        ddr_init_done = 1'b0;
        model_reload();
        expect_idle(20);
        ddr_init_done = 1'b1;
        do_burst(2, 0, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ddr_rd_arbiter.md
# ddr_rd_arbiter

Two-channel DDR read scheduler for the dual-camera picture-in-picture display path. It shares one DDR read command/data port between the CH0 and CH1 display FIFOs. Each FIFO's fill level is watched, and fixed-length bursts are issued from per-channel frame buffers. Returned 64-bit words are steered into the requesting FIFO, which the display side drains via its ch0/ch1 read enables.

## Interface
- BURST_LEN, 64: words (64-bit) per read burst; power of two, ≤ 256.
- ADDR_W, 28: width of the word address.
- LVL_W, 10: width of the FIFO level inputs.
- LOW_WATER, 384: a channel requests when its level ≤ LOW_WATER; the constraint LOW_WATER + BURST_LEN ≤ FIFO depth is mandatory.
- FRAME_WORDS, 76800: words per channel per frame (640×480 RGB565, 4 pixels/word).
- CH0_BASE, 0: CH0 frame base word address.
- CH1_BASE, 'h200000: CH1 frame base word address.
- ddr_clk  in  1  single clock; all logic on its rising edge.
- ddr_rst  in  1  synchronous, active-high reset.
- ddr_init_done  in  1  DDR calibration complete; no command is issued while low.
- frame_start  in  1  one-cycle pulse, already in ddr_clk domain; restarts both channels at frame top.
- ch0_fifo_level  in  LVL_W  CH0 FIFO word count.
- ch1_fifo_level  in  LVL_W  CH1 FIFO word count.
- rd_cmd_valid  out  1  read command valid.
- rd_cmd_ready  in  1  DDR port accepts command.
- rd_cmd_addr  out  ADDR_W  burst start word address.
- rd_cmd_len  out  9  burst length in words (1..BURST_LEN).
- rd_data_valid  in  1  one returned word per cycle when high.
- rd_data  in  64  returned word.
- ch0_fifo_wr_en  out  1  write strobe, CH0 FIFO.
- ch1_fifo_wr_en  out  1  write strobe, CH1 FIFO.
- fifo_wr_data  out  64  registered copy of rd_data, shared by both FIFOs.
- busy  out  1  high in CMD or DATA.

## Operation
- States: IDLE, ARB, CMD, DATA.
- IDLE: remain until ddr_init_done = 1, then go to ARB. Per-channel address = base and remaining = FRAME_WORDS are already loaded at reset.
- Eligibility: channel eligible when level ≤ LOW_WATER and remaining ≠ 0.
- ARB:
  - If frame_start or a pending frame restart is present: reload both channels (addr = base, remaining = FRAME_WORDS), clear pending, set round-robin pointer to CH0. No grant in that cycle.
  - Otherwise, if any channel is eligible: grant per the round-robin pointer, which favours the channel not granted last. Latch addr and len = min(BURST_LEN, remaining), then go to CMD.
- CMD:
  - rd_cmd_valid = 1; addr and len are held stable until rd_cmd_ready.
  - On the handshake: that channel's addr += len and remaining -= len; go to DATA.
- DATA:
  - Each rd_data_valid writes to the granted channel FIFO and increments the beat counter.
  - After the len-th beat, go to ARB.
  - rd_data_valid outside DATA is ignored.
- frame_start seen in CMD or DATA sets pending. The current burst completes, and the reload happens at the next ARB cycle.
- A channel with remaining = 0 stays idle until the next frame reload.

## Timing
- Reset values: rd_cmd_valid 0, rd_cmd_addr 0, rd_cmd_len 0, ch0/ch1_fifo_wr_en 0, fifo_wr_data 0, busy 0, state IDLE, pending 0, pointer CH0.
- Request latency: eligibility in ARB at cycle N gives rd_cmd_valid = 1 at N+1.
- rd_cmd_valid deasserts the cycle after the handshake, with busy staying high. Back-to-back commands are separated by at least one ARB cycle.
- Write latency: rd_data_valid at cycle N gives chX_fifo_wr_en = 1 and fifo_wr_data = rd_data at N+1.
- Reset asserted mid-burst: all outputs clear on the next edge, state goes to IDLE, and in-flight data is dropped. The DDR port must also be reset.
- ddr_init_done falling outside IDLE has no effect.

## Configuration
- DDR_RD_ARB_FIXED_PRIO_EN defined: CH0 always wins when both channels are eligible, and the round-robin pointer is unused.
- Undefined: round-robin arbitration as above (default build).

## Test plan
- Init gating: hold ddr_init_done = 0 with both levels at 0 for 100 cycles, then raise it. Required: no rd_cmd_valid before the raise; then CH0 command at CH0_BASE, len 64.
- Round-robin: both levels at 0, rd_cmd_ready = 1, data returned immediately. Required: commands alternate CH0, CH1, CH0, with addresses CH0_BASE, CH1_BASE, CH0_BASE+64, and exactly 64 wr_en pulses per burst on the correct channel.
- Watermark: CH0 level = 385, CH1 level = 0. Required: only CH1 bursts. Drop CH0 level to 384 and CH0 is granted next ARB.
- Frame tail: FRAME_WORDS = 100. Required: CH0 bursts of len 64 then 36, then no more CH0 commands until frame_start.
- frame_start during DATA beat 10: burst finishes all 64 beats. The next ARB cycle reloads, and the next command is CH0 at CH0_BASE.
- Backpressure: hold rd_cmd_ready = 0 for 20 cycles. Required: rd_cmd_valid, addr and len stay stable, and exactly one handshake occurs.
